// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared multi-cycle ALU.
// Optional macro ALU_ARB_FLAGS_EN builds a register that captures alu_flags into rsp_flags.
module alu_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [7:0]  req_opcode,
    input  logic [1:0]  req_mode,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_opcode,
    output logic        alu_mode,
    input  logic [63:0] alu_out,
    input  logic [4:0]  alu_flags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_result,
    output logic [4:0]  rsp_flags,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    localparam logic [1:0] CNT_LAST = 2'(SETTLE_CYCLES - 1);

    state_t     state;
    logic       ptr;
    logic [1:0] cnt;
    logic       gnt_any;
    logic       gnt_id;

    // Grant is combinational and suppressed while reset is held.
    always_comb begin
        gnt_any   = (state == IDLE) && rst_n && (req_valid != 2'b00);
        gnt_id    = (req_valid == 2'b11) ? ptr : req_valid[1];
        req_ready = '0;
        if (gnt_any) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

`ifdef ALU_ARB_FLAGS_EN
    logic [4:0] flags_q;
    assign rsp_flags = flags_q;
`else
    logic unused_flags;
    assign unused_flags = ^alu_flags;
    assign rsp_flags    = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            alu_mode   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            busy       <= 1'b0;
`ifdef ALU_ARB_FLAGS_EN
            flags_q    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        alu_a      <= req_a[{gnt_id, 5'd0} +: 32];
                        alu_b      <= req_b[{gnt_id, 5'd0} +: 32];
                        alu_opcode <= req_opcode[{gnt_id, 2'd0} +: 4];
                        alu_mode   <= req_mode[gnt_id];
                        rsp_id     <= gnt_id;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == CNT_LAST) begin
                        rsp_result <= alu_out;
`ifdef ALU_ARB_FLAGS_EN
                        flags_q    <= alu_flags;
`endif
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= ~rsp_id;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic against a
// transaction-timing reference model; a second instance exercises SETTLE_CYCLES=3.
`timescale 1ns/1ps
module tb_alu_arbiter;

    localparam int unsigned S = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        rst_n;
    logic [1:0]  req_valid, req_ready;
    logic [63:0] req_a, req_b;
    logic [7:0]  req_opcode;
    logic [1:0]  req_mode;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_opcode;
    logic        alu_mode;
    logic [63:0] alu_out;
    logic [4:0]  alu_flags;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [63:0] rsp_result;
    logic [4:0]  rsp_flags;

    logic        ovr_en, ovr_f;
    logic [63:0] ovr_out;
    logic [4:0]  ovr_flags;

    logic [1:0]  x3_req_valid, x3_req_ready;
    logic [63:0] x3_req_a, x3_req_b;
    logic [7:0]  x3_req_opcode;
    logic [1:0]  x3_req_mode;
    logic [31:0] x3_alu_a, x3_alu_b;
    logic [3:0]  x3_alu_opcode;
    logic        x3_alu_mode;
    logic [63:0] x3_alu_out;
    logic [4:0]  x3_alu_flags;
    logic        x3_rsp_valid, x3_rsp_ready, x3_rsp_id, x3_busy;
    logic [63:0] x3_rsp_result;
    logic [4:0]  x3_rsp_flags;

    alu_arbiter #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode), .req_mode(req_mode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_mode(alu_mode),
        .alu_out(alu_out), .alu_flags(alu_flags), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .busy(busy)
    );

    alu_arbiter #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(x3_req_valid), .req_ready(x3_req_ready),
        .req_a(x3_req_a), .req_b(x3_req_b), .req_opcode(x3_req_opcode), .req_mode(x3_req_mode),
        .alu_a(x3_alu_a), .alu_b(x3_alu_b), .alu_opcode(x3_alu_opcode), .alu_mode(x3_alu_mode),
        .alu_out(x3_alu_out), .alu_flags(x3_alu_flags), .rsp_valid(x3_rsp_valid),
        .rsp_ready(x3_rsp_ready), .rsp_id(x3_rsp_id), .rsp_result(x3_rsp_result),
        .rsp_flags(x3_rsp_flags), .busy(x3_busy)
    );

    function automatic logic [63:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [3:0] op, logic m);
        logic [63:0] ea, eb;
        ea = {32'd0, a};
        eb = {32'd0, b};
        if (!m) begin
            case (op[1:0])
                2'd0:    return ea + eb;
                2'd1:    return ea - eb;
                2'd2:    return ea * eb;
                default: return {a, b};
            endcase
        end else begin
            case (op[1:0])
                2'd0:    return ea & eb;
                2'd1:    return ea | eb;
                2'd2:    return ea ^ eb;
                default: return ~(ea & eb);
            endcase
        end
    endfunction

    function automatic logic [4:0] flag_fn(logic [31:0] a, logic [31:0] b);
        return {a == 32'd0, b == 32'd0, a == b, a > b, a < b};
    endfunction

    // Environment ALU: responds to whatever operands the arbiter presents.
    always_comb begin
        alu_out   = ovr_en ? ovr_out : alu_fn(alu_a, alu_b, alu_opcode, alu_mode);
        alu_flags = ovr_f ? ovr_flags : flag_fn(alu_a, alu_b);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: transaction timing. A grant at cycle g yields a response from
    // cycle g+S+1 on, computed from the granted operands; the next grant may come
    // only the cycle after that response is taken.
    int          t = 0;
    bit          m_out = 0, m_id = 0, m_ptr = 0, m_gany = 0, m_gid = 0;
    int          m_due = 0;
    logic [31:0] m_a = '0, m_b = '0;
    logic [3:0]  m_op = '0;
    logic        m_md = 1'b0;
    logic [63:0] m_res = '0;
    logic [4:0]  m_flg = '0;
    bit          exp_rv;

    task automatic check_cycle();
        logic [1:0] exp_ready;
        @(negedge clk);
        exp_rv = m_out && (t >= m_due);
        m_gany = rst_n && !m_out && (req_valid != 2'b00);
        if (req_valid == 2'b11) m_gid = m_ptr;
        else                    m_gid = (req_valid == 2'b10);
        exp_ready = !m_gany ? 2'b00 : (m_gid ? 2'b10 : 2'b01);
        chk("req_ready", req_ready, exp_ready);
        chk("busy", busy, m_out);
        chk("rsp_valid", rsp_valid, exp_rv);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_opcode", alu_opcode, m_op);
        chk("alu_mode", alu_mode, m_md);
        if (exp_rv) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_flags", rsp_flags, m_flg);
        end
    endtask

    task automatic advance();
        if (!rst_n) begin
            m_out = 0; m_ptr = 0;
            m_a = '0; m_b = '0; m_op = '0; m_md = 1'b0;
        end else if (m_gany) begin
            m_out = 1;
            m_id  = m_gid;
            m_a   = m_gid ? req_a[63:32] : req_a[31:0];
            m_b   = m_gid ? req_b[63:32] : req_b[31:0];
            m_op  = m_gid ? req_opcode[7:4] : req_opcode[3:0];
            m_md  = req_mode[m_gid];
            m_due = t + int'(S) + 1;
        end else if (m_out && t == m_due - 1) begin
            m_res = ovr_en ? ovr_out : alu_fn(m_a, m_b, m_op, m_md);
`ifdef ALU_ARB_FLAGS_EN
            m_flg = ovr_f ? ovr_flags : flag_fn(m_a, m_b);
`else
            m_flg = '0;
`endif
        end else if (m_out && t >= m_due && rsp_ready) begin
            m_out = 0;
            m_ptr = !m_id;
        end
        @(posedge clk);
        t++;
        #1;
    endtask

    task automatic step();
        check_cycle();
        advance();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_alu_a"}, alu_a, 0);
        chk({tag, "_alu_b"}, alu_b, 0);
        chk({tag, "_alu_op"}, alu_opcode, 0);
        chk({tag, "_alu_mode"}, alu_mode, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_rsp_result"}, rsp_result, 0);
        chk({tag, "_rsp_flags"}, rsp_flags, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic new_req(input int i);
        req_a[32*i +: 32]     = $urandom;
        req_b[32*i +: 32]     = $urandom;
        req_opcode[4*i +: 4]  = 4'($urandom);
        req_mode[i]           = 1'($urandom);
        req_valid[i]          = 1'b1;
    endtask

    initial begin
        int g, last;
        logic [63:0] held;
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_opcode = '0; req_mode = '0;
        rsp_ready = 1'b0; ovr_en = 1'b0; ovr_f = 1'b0; ovr_out = '0; ovr_flags = '0;
        x3_req_valid = '0; x3_req_a = '0; x3_req_b = '0; x3_req_opcode = '0; x3_req_mode = '0;
        x3_alu_out = '0; x3_alu_flags = '0; x3_rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        check_cycle(); chk_zero("reset"); advance();

        // Single requester 0: 5 + 3
        rst_n = 1'b1; req_valid = 2'b01; req_a = 64'd5; req_b = 64'd3; req_opcode = '0; req_mode = '0;
        rsp_ready = 1'b1;
        check_cycle(); chk("single_grant", req_ready, 2'b01); advance();
        req_valid = 2'b00;
        check_cycle(); chk("single_settle_ready", req_ready, 0); chk("single_settle_rv", rsp_valid, 0); advance();
        check_cycle(); chk("single_rv", rsp_valid, 1); chk("single_id", rsp_id, 0);
        chk("single_result", rsp_result, 64'd8); advance();

        // Both valid from reset: strict alternation, 3 cycles apart
        rst_n = 1'b0; step(); rst_n = 1'b1;
        new_req(0); new_req(1); rsp_ready = 1'b1;
        g = 0; last = -1;
        for (int k = 0; k < 12; k++) begin
            check_cycle();
            if (req_ready != 2'b00) begin
                chk("rr_order", req_ready, (g % 2 == 1) ? 2'b10 : 2'b01);
                if (last >= 0) chk("rr_spacing", 64'(t - last), 64'd3);
                last = t;
                g++;
            end
            advance();
        end
        chk("rr_count", 64'(g), 64'd4);

        // Back-pressure: response held while rsp_ready stays low
        req_valid = 2'b01; req_a[31:0] = 32'h1234; req_b[31:0] = 32'h0F0F; req_opcode[3:0] = 4'h6;
        req_mode[0] = 1'b1; rsp_ready = 1'b0;
        held = alu_fn(32'h1234, 32'h0F0F, 4'h6, 1'b1);
        step();
        req_valid = 2'b11;
        step();
        for (int k = 0; k < 4; k++) begin
            check_cycle();
            chk("hold_rv", rsp_valid, 1);
            chk("hold_result", rsp_result, held);
            chk("hold_ready", req_ready, 0);
            chk("hold_busy", busy, 1);
            advance();
        end
        rsp_ready = 1'b1;
        step();
        req_valid = 2'b00;
        step();

        // Reset during SETTLE discards the operation
        req_valid = 2'b01;
        step();
        req_valid = 2'b00; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_cycle(); chk_zero("midrst"); advance();
        for (int k = 0; k < 5; k++) begin
            check_cycle(); chk("midrst_no_rsp", rsp_valid, 0); advance();
        end

        // Flags capture
        ovr_f = 1'b1; ovr_flags = 5'b10100; req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        step();
        check_cycle();
        chk("flags_rv", rsp_valid, 1);
`ifdef ALU_ARB_FLAGS_EN
        chk("flags_val", rsp_flags, 5'b10100);
`else
        chk("flags_val", rsp_flags, 5'b00000);
`endif
        advance();
        ovr_f = 1'b0;

        // Random traffic with drops and random back-pressure
        for (int k = 0; k < 400; k++) begin
            bit gv;
            bit gi;
            check_cycle();
            gv = m_gany;
            gi = m_gid;
            advance();
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && gv && (gi == i)) req_valid[i] = 1'b0;
                else if (req_valid[i] && ($urandom_range(19) == 0)) req_valid[i] = 1'b0;
                else if (!req_valid[i] && ($urandom_range(2) == 0)) new_req(i);
            end
            rsp_ready = ($urandom_range(2) != 0);
        end
        req_valid = 2'b00; rsp_ready = 1'b1;
        repeat (6) step();

        // SETTLE_CYCLES=3: result sampled on the third settle cycle
        x3_req_valid = 2'b01; x3_req_a = 64'd7; x3_req_b = 64'd9; x3_rsp_ready = 1'b1;
        x3_alu_out = 64'h100;
        @(negedge clk); chk("s3_grant", x3_req_ready, 2'b01);
        @(posedge clk); #1;
        x3_req_valid = 2'b00;
        for (int k = 1; k <= 3; k++) begin
            x3_alu_out = 64'h1111 * 64'(k);
            @(negedge clk);
            chk("s3_settle_rv", x3_rsp_valid, 0);
            chk("s3_settle_busy", x3_busy, 1);
            @(posedge clk); #1;
        end
        x3_alu_out = 64'hDEAD;
        @(negedge clk);
        chk("s3_rv", x3_rsp_valid, 1);
        chk("s3_id", x3_rsp_id, 0);
        chk("s3_result", x3_rsp_result, 64'h3333);
        chk("s3_alu_a", x3_alu_a, 64'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, range 1..4: cycles the ALU operands are held stable before the result is captured.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port req_valid, input, 2: per-requester request valid; bit i is requester i.
REQ-005 SHALL have port req_ready, output, 2: per-requester accept strobe.
REQ-006 SHALL have port req_a, input, 64: operand a; requester i in bits [32i+31:32i].
REQ-007 SHALL have port req_b, input, 64: operand b; packed as req_a.
REQ-008 SHALL have port req_opcode, input, 8: 4-bit opcode per requester; requester i in [4i+3:4i].
REQ-009 SHALL have port req_mode, input, 2: per-requester mode; 0 arithmetic, 1 logic.
REQ-010 SHALL have ports alu_a (output, 32), alu_b (output, 32), alu_opcode (output, 4), alu_mode (output, 1): operands driven to the shared ALU.
REQ-011 SHALL have port alu_out, input, 64: ALU result.
REQ-012 SHALL have port alu_flags, input, 5: ALU flags {za,zb,eq,gt,lt}.
REQ-013 SHALL have port rsp_valid, output, 1: response valid.
REQ-014 SHALL have port rsp_ready, input, 1: response consumer ready.
REQ-015 SHALL have port rsp_id, output, 1: index of the requester owning the response.
REQ-016 SHALL have port rsp_result, output, 64: captured ALU result.
REQ-017 SHALL have port rsp_flags, output, 5: captured ALU flags.
REQ-018 SHALL have port busy, output, 1: high whenever the FSM is not IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, SETTLE and RESP; one operation in flight at a time.
REQ-020 In IDLE with any req_valid bit set, SHALL grant one requester and assert req_ready for that bit only, combinationally, for that single cycle; the FSM SHALL then go to SETTLE.
REQ-021 When both requesters are valid, SHALL grant the requester selected by a round-robin pointer; with only one valid, SHALL grant that one regardless of the pointer.
REQ-022 On grant, SHALL latch the granted requester's operands, opcode and mode into alu_a, alu_b, alu_opcode and alu_mode, and hold them unchanged until the next grant.
REQ-023 SHALL remain in SETTLE for exactly SETTLE_CYCLES cycles, then capture alu_out and alu_flags into rsp_result and rsp_flags on the last SETTLE edge, and enter RESP.
REQ-024 In RESP, SHALL hold rsp_valid high with stable rsp_id, rsp_result and rsp_flags until the first cycle in which rsp_ready is high.
REQ-025 On that cycle, SHALL set the pointer to the non-granted requester and return to IDLE; no new grant is made in that same cycle.
REQ-026 req_ready SHALL be 0 in SETTLE and RESP; a request deasserted before it is accepted is dropped without side effects.
REQ-027 With SETTLE_CYCLES=1 and rsp_ready held high, SHALL sustain one operation per 3 cycles (grant-to-grant).

Reset
REQ-028 When rst_n is low at a clock edge, SHALL enter IDLE, set the pointer to 0, and clear all of req_ready, alu_a, alu_b, alu_opcode, alu_mode, rsp_valid, rsp_id, rsp_result, rsp_flags and busy.
REQ-029 A reset during SETTLE or RESP SHALL discard the in-flight operation with no response issued.

Configuration
REQ-030 With macro ALU_ARB_FLAGS_EN defined, rsp_flags SHALL carry the captured alu_flags; without it, rsp_flags SHALL be tied to 5'b0 and no flag register SHALL be built.

Verification
REQ-031 Bench SHALL cover: only requester 0 valid, a=5, b=3, ALU model returns 64'd8 -> req_ready=2'b01 for one cycle, rsp_valid 2 cycles after grant with rsp_id=0, rsp_result=8.
REQ-032 Bench SHALL cover: both valid out of reset -> requester 0 granted first; with both still valid, the next grant goes to requester 1; the pattern continues alternating 0,1,0,1.
REQ-033 Bench SHALL cover: rsp_ready held low for 4 cycles in RESP -> rsp_valid and rsp_result stable throughout, req_ready=0, busy=1.
REQ-034 Bench SHALL cover: rst_n low during SETTLE -> next cycle in IDLE, rsp_valid=0, all outputs 0, and no response is ever issued for that operation.
REQ-035 Bench SHALL cover: SETTLE_CYCLES=3, ALU model output changed one cycle after grant -> the captured result equals alu_out at the third SETTLE cycle.
REQ-036 Bench SHALL cover: ALU model flags 5'b10100, run with and without ALU_ARB_FLAGS_EN -> rsp_flags=5'b10100 with the macro, 5'b00000 without it.
